// File: rtl/board_drop.sv
// Connect Four board register and move sequencer.
// Places pieces, alternates turns, and detects game over from win_check.
module board_drop (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        drop_valid,
    input  logic [2:0]  drop_col,
    input  logic [1:0]  win,
    output logic [11:0] col1,
    output logic [11:0] col2,
    output logic [11:0] col3,
    output logic [11:0] col4,
    output logic [11:0] col5,
    output logic [11:0] col6,
    output logic [11:0] col7,
    output logic        drop_ready,
    output logic        drop_ack,
    output logic        drop_err,
    output logic        turn,
    output logic [2:0]  last_row,
    output logic [2:0]  last_col,
    output logic [5:0]  moves,
    output logic [1:0]  winner,
    output logic        draw,
    output logic        game_over
);

    typedef enum logic [1:0] {PLAY, PLACE, SETTLE, OVER} state_t;

    state_t            state_q, state_d;
    logic [6:0][11:0]  board_q, board_d;
    logic [6:0][2:0]   height_q, height_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        last_row_q, last_row_d;
    logic [2:0]        last_col_q, last_col_d;
    logic [5:0]        moves_q, moves_d;
    logic [1:0]        winner_q, winner_d;
    logic              draw_q, draw_d;
    logic              turn_q, turn_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              req_full;

    // Column-indexed lookups are unrolled so out-of-range columns never index the arrays.
    always_comb begin
        req_full = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (drop_col == 3'(i)) req_full = (height_q[i] == 3'd6);
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        height_d   = height_q;
        col_d      = col_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        moves_d    = moves_q;
        winner_d   = winner_q;
        draw_d     = draw_q;
        turn_d     = turn_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        if (new_game) begin
            state_d    = PLAY;
            board_d    = '0;
            height_d   = '0;
            col_d      = '0;
            last_row_d = '0;
            last_col_d = '0;
            moves_d    = '0;
            winner_d   = '0;
            draw_d     = 1'b0;
            turn_d     = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (drop_valid) begin
                        if (req_full) begin
                            err_d = 1'b1;
                        end else begin
                            col_d   = drop_col;
                            state_d = PLACE;
                        end
                    end
                end
                PLACE: begin
                    for (int i = 0; i < 7; i++) begin
                        if (col_q == 3'(i)) begin
                            board_d[i][{height_q[i], 1'b0} +: 2] = turn_q ? 2'b10 : 2'b01;
                            last_row_d  = height_q[i];
                            height_d[i] = height_q[i] + 3'd1;
                        end
                    end
                    last_col_d = col_q;
                    moves_d    = moves_q + 6'd1;
                    state_d    = SETTLE;
                end
                SETTLE: begin
                    ack_d = 1'b1;
                    // A win on the final move outranks the draw; turn keeps the last mover.
                    if (win != 2'b00) begin
                        winner_d = win;
                        state_d  = OVER;
                    end else if (moves_q == 6'd42) begin
                        draw_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PLAY;
            board_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            moves_q    <= '0;
            winner_q   <= '0;
            draw_q     <= 1'b0;
            turn_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            height_q   <= height_d;
            col_q      <= col_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            moves_q    <= moves_d;
            winner_q   <= winner_d;
            draw_q     <= draw_d;
            turn_q     <= turn_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign col1       = board_q[0];
    assign col2       = board_q[1];
    assign col3       = board_q[2];
    assign col4       = board_q[3];
    assign col5       = board_q[4];
    assign col6       = board_q[5];
    assign col7       = board_q[6];
    assign drop_ready = (state_q == PLAY);
    assign game_over  = (state_q == OVER);
    assign drop_ack   = ack_q;
    assign drop_err   = err_q;
    assign turn       = turn_q;
    assign last_row   = last_row_q;
    assign last_col   = last_col_q;
    assign moves      = moves_q;
    assign winner     = winner_q;
    assign draw       = draw_q;

endmodule

// File: tb/tb_board_drop.sv
// Directed bench for board_drop with a vertical-only win_check stand-in.
module tb_board_drop;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic        drop_valid = 1'b0;
    logic [2:0]  drop_col = 3'd0;
    logic [1:0]  win;
    logic [11:0] col1, col2, col3, col4, col5, col6, col7;
    logic        drop_ready, drop_ack, drop_err, turn, draw, game_over;
    logic [2:0]  last_row, last_col;
    logic [5:0]  moves;
    logic [1:0]  winner;
    logic        win_en = 1'b1;

    int checks = 0;
    int errors = 0;

    board_drop dut (
        .clk(clk), .rst(rst), .new_game(new_game), .drop_valid(drop_valid),
        .drop_col(drop_col), .win(win),
        .col1(col1), .col2(col2), .col3(col3), .col4(col4),
        .col5(col5), .col6(col6), .col7(col7),
        .drop_ready(drop_ready), .drop_ack(drop_ack), .drop_err(drop_err),
        .turn(turn), .last_row(last_row), .last_col(last_col), .moves(moves),
        .winner(winner), .draw(draw), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Four equal non-empty cells stacked in one column; the code doubles as the win bit.
    function automatic logic [1:0] vwin(input logic [11:0] c);
        logic [1:0] w;
        w = 2'b00;
        for (int r = 0; r < 3; r++) begin
            if (c[2*r +: 2] != 2'b00 && c[2*r +: 2] == c[2*r+2 +: 2] &&
                c[2*r +: 2] == c[2*r+4 +: 2] && c[2*r +: 2] == c[2*r+6 +: 2])
                w = w | c[2*r +: 2];
        end
        return w;
    endfunction

    always_comb begin
        win = 2'b00;
        if (win_en)
            win = vwin(col1) | vwin(col2) | vwin(col3) | vwin(col4) |
                  vwin(col5) | vwin(col6) | vwin(col7);
    end

    task automatic do_drop(input logic [2:0] c, output bit got_ack, output bit got_err);
        got_ack = 1'b0;
        got_err = 1'b0;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = c;
        @(negedge clk);
        drop_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (drop_err) begin got_err = 1'b1; break; end
            if (drop_ack) begin got_ack = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (moves !== 6'd0 || col1 !== 12'h0 || turn !== 1'b0 || winner !== 2'b00 ||
            draw !== 1'b0 || drop_ack !== 1'b0 || drop_err !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_state moves=%0d col1=%h turn=%b winner=%b draw=%b ack=%b err=%b over=%b",
                     moves, col1, turn, winner, draw, drop_ack, drop_err, game_over);
        end
        checks++;
        if (drop_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", drop_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bad_col();
        bit a, e;
        do_drop(3'd7, a, e);
        checks++;
        if (e !== 1'b1 || a !== 1'b0) begin
            errors++;
            $display("FAIL bad_col_err got err=%b ack=%b want err=1 ack=0", e, a);
        end
        checks++;
        if (drop_ready !== 1'b1 || moves !== 6'd0 || col1 !== 12'h0 || col7 !== 12'h0) begin
            errors++;
            $display("FAIL bad_col_state ready=%b moves=%0d col1=%h col7=%h want 1/0/0/0",
                     drop_ready, moves, col1, col7);
        end
        @(negedge clk);
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_col_pulse err still=%b want 0", drop_err);
        end
    endtask

    task automatic test_col_full();
        bit a, e;
        int nack;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            do_drop(3'd3, a, e);
            if (a) nack++;
        end
        checks++;
        if (nack !== 6 || col4 !== 12'h999 || moves !== 6'd6 || last_row !== 3'd5 || last_col !== 3'd3) begin
            errors++;
            $display("FAIL col_fill acks=%0d col4=%h moves=%0d last=%0d,%0d want 6/999/6/5,3",
                     nack, col4, moves, last_row, last_col);
        end
        do_drop(3'd3, a, e);
        checks++;
        if (e !== 1'b1 || a !== 1'b0) begin
            errors++;
            $display("FAIL col_full_err got err=%b ack=%b want err=1 ack=0", e, a);
        end
        checks++;
        if (col4 !== 12'h999 || moves !== 6'd6 || turn !== 1'b0 || drop_ready !== 1'b1) begin
            errors++;
            $display("FAIL col_full_state col4=%h moves=%0d turn=%b ready=%b want 999/6/0/1",
                     col4, moves, turn, drop_ready);
        end
    endtask

    task automatic test_vertical_win();
        bit a, e;
        logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        pulse_new_game();
        for (int i = 0; i < 7; i++) begin
            do_drop(seq[i], a, e);
            checks++;
            if (a !== 1'b1) begin
                errors++;
                $display("FAIL win_seq_ack move=%0d ack=%b want 1", i, a);
            end
        end
        checks++;
        if (col1 !== 12'h055 || col2 !== 12'h02A) begin
            errors++;
            $display("FAIL win_board col1=%h col2=%h want 055/02a", col1, col2);
        end
        checks++;
        if (winner !== 2'b01 || game_over !== 1'b1 || moves !== 6'd7 || turn !== 1'b0 ||
            draw !== 1'b0 || drop_ready !== 1'b0) begin
            errors++;
            $display("FAIL win_state winner=%b over=%b moves=%0d turn=%b draw=%b ready=%b want 01/1/7/0/0/0",
                     winner, game_over, moves, turn, draw, drop_ready);
        end
    endtask

    task automatic test_over_ignore();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 3'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (drop_ack || drop_err) seen = 1'b1;
        end
        drop_valid = 1'b0;
        checks++;
        if (seen !== 1'b0 || moves !== 6'd7 || col3 !== 12'h0) begin
            errors++;
            $display("FAIL over_ignore ack_or_err=%b moves=%0d col3=%h want 0/7/0", seen, moves, col3);
        end
        @(negedge clk);
        new_game   = 1'b1;
        drop_valid = 1'b1;
        drop_col   = 3'd0;
        @(negedge clk);
        new_game   = 1'b0;
        drop_valid = 1'b0;
        checks++;
        if ((col1 | col2 | col3 | col4 | col5 | col6 | col7) !== 12'h0 || moves !== 6'd0 ||
            drop_ready !== 1'b1 || game_over !== 1'b0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL new_game_clear col1=%h col2=%h moves=%0d ready=%b over=%b winner=%b",
                     col1, col2, moves, drop_ready, game_over, winner);
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (drop_ack || drop_err) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || moves !== 6'd0) begin
            errors++;
            $display("FAIL new_game_discard ack_or_err=%b moves=%0d want 0/0", seen, moves);
        end
    endtask

    task automatic test_draw();
        bit a, e;
        int nack;
        nack = 0;
        win_en = 1'b0;
        pulse_new_game();
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                do_drop(3'(c), a, e);
                if (a) nack++;
            end
        end
        checks++;
        if (nack !== 42 || moves !== 6'd42) begin
            errors++;
            $display("FAIL draw_fill acks=%0d moves=%0d want 42/42", nack, moves);
        end
        checks++;
        if (draw !== 1'b1 || winner !== 2'b00 || drop_ready !== 1'b0 || game_over !== 1'b1 || turn !== 1'b1) begin
            errors++;
            $display("FAIL draw_state draw=%b winner=%b ready=%b over=%b turn=%b want 1/00/0/1/1",
                     draw, winner, drop_ready, game_over, turn);
        end
        checks++;
        if (col7 !== 12'h999 || last_row !== 3'd5 || last_col !== 3'd6) begin
            errors++;
            $display("FAIL draw_board col7=%h last=%0d,%0d want 999/5,6", col7, last_row, last_col);
        end
        win_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit a, e, seen;
        pulse_new_game();
        do_drop(3'd2, a, e);
        checks++;
        if (a !== 1'b1 || col3 !== 12'h001 || moves !== 6'd1 || turn !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup ack=%b col3=%h moves=%0d turn=%b want 1/001/1/1", a, col3, moves, turn);
        end
        @(negedge clk);
        drop_valid = 1'b1;
        drop_col   = 3'd2;
        @(negedge clk);
        drop_valid = 1'b0;
        checks++;
        if (drop_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_place ready=%b want 0", drop_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (moves !== 6'd0 || col3 !== 12'h0 || turn !== 1'b0 || last_col !== 3'd0 || drop_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_clear moves=%0d col3=%h turn=%b last_col=%0d ready=%b want 0/0/0/0/1",
                     moves, col3, turn, last_col, drop_ready);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (drop_ack || drop_err) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || moves !== 6'd0 || col3 !== 12'h0) begin
            errors++;
            $display("FAIL mid_no_ack ack_or_err=%b moves=%0d col3=%h want 0/0/0", seen, moves, col3);
        end
    endtask

    initial begin
        test_reset();
        test_bad_col();
        test_col_full();
        test_vertical_win();
        test_over_ignore();
        test_draw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
